// File: rtl/seqarith_pkg.sv
// Shared definitions for the sequential arithmetic units.
// State encodings, divide-by-zero quotient and counter sizing.
package seqarith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [63:0] DIV_ZERO_QUOT = '1;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/registerNbits.sv
// Generic W-bit result register with load enable.
// Cleared asynchronously by reset.
module registerNbits #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // load d when enabled, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/sequential_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Results are registered and held until the next completion.
module sequential_divider
  import seqarith_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_width(N);

  state_t         state;
  state_t         state_nx;
  logic [N-1:0]   p;
  logic [N-1:0]   q_sh;
  logic [N-1:0]   d_reg;
  logic [CW-1:0]  cnt;
  logic           dz;
  logic           accept;
  logic           load;
  logic [N:0]     p_sh;
  logic [N:0]     p_sub;
  logic           p_ge;
  logic [N-1:0]   quot_d;
  logic [N-1:0]   rem_d;

  // shift in the next dividend bit and trial-subtract the divisor;
  // a non-negative difference means the quotient bit is 1
  assign p_sh  = {p, q_sh[N-1]};
  assign p_sub = p_sh - {1'b0, d_reg};
  assign p_ge  = ~p_sub[N];

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else state <= state_nx;
  end

  // next state; DONE spends one cycle loading, one cycle with done high
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = (divisor == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == '0) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (done) state_nx = ST_IDLE;
        else load = 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // datapath: operand capture and one restoring step per RUN cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p     <= '0;
      q_sh  <= '0;
      d_reg <= '0;
      cnt   <= '0;
      dz    <= 1'b0;
    end else if (accept) begin
      p     <= '0;
      q_sh  <= dividend;
      d_reg <= divisor;
      cnt   <= CW'(N - 1);
      dz    <= (divisor == '0);
    end else if (state == ST_RUN) begin
      p    <= p_ge ? p_sub[N-1:0] : p_sh[N-1:0];
      q_sh <= {q_sh[N-2:0], p_ge};
      cnt  <= cnt - CW'(1);
    end
  end

  // handshake flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= load;
      if (accept) busy <= 1'b1;
      else if (load) busy <= 1'b0;
    end
  end

  // divide by zero leaves the dividend untouched in the shift register
  assign quot_d = dz ? DIV_ZERO_QUOT[N-1:0] : q_sh;
  assign rem_d  = dz ? q_sh : p;

  registerNbits #(.W(N)) u_quot (
    .clk   (clk),
    .reset (reset),
    .en    (load),
    .d     (quot_d),
    .q     (quotient)
  );

  registerNbits #(.W(N)) u_rem (
    .clk   (clk),
    .reset (reset),
    .en    (load),
    .d     (rem_d),
    .q     (remainder)
  );

  registerNbits #(.W(1)) u_dz (
    .clk   (clk),
    .reset (reset),
    .en    (load),
    .d     (dz),
    .q     (div_by_zero)
  );

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider.
// Stimulus pushes expected results; a monitor checks each done.
module tb_sequential_divider;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  sequential_divider #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // issue one op, check latency and busy length, wait for done to fall
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] eq, input logic [N-1:0] er,
                        input logic edz, input bit pulse);
    exp_t e;
    int   lat;
    int   bcyc;
    bit   seen;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    e.q  = eq;
    e.r  = er;
    e.dz = edz;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat  = 0;
    bcyc = busy ? 1 : 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (pulse) begin
        start = (lat == 5 || lat == 20);
        if (start) begin
          dividend = 1000;
          divisor  = 10;
        end
      end
      if (done) seen = 1'b1;
      else if (busy) bcyc++;
    end
    start = 1'b0;
    chk("done_seen", 64'(seen), 1);
    chk("latency", 64'(lat), edz ? 1 : N + 1);
    chk("busy_cycles", 64'(bcyc), edz ? 1 : N + 1);
    @(posedge clk);
  endtask

  // monitor: every done must match the oldest expected result
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      chk("done_busy_overlap", 64'(busy), 0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected none at %0t",
                 $time);
      end else begin
        e = sb.pop_front();
        chk("quotient", 64'(quotient), 64'(e.q));
        chk("remainder", 64'(remainder), 64'(e.r));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
      end
    end
  end

  initial begin
    logic [N-1:0] a;
    logic [N-1:0] b;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quotient", 64'(quotient), 0);
    chk("rst_remainder", 64'(remainder), 0);
    chk("rst_dz", 64'(div_by_zero), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    @(negedge clk);
    reset = 1'b0;

    run_op(100, 7, 14, 2, 1'b0, 1'b0);
    run_op(32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 1'b0, 1'b0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 1'b0, 1'b0);
    run_op(5, 0, 32'hFFFFFFFF, 5, 1'b1, 1'b0);
    run_op(9, 3, 3, 0, 1'b0, 1'b0);
    run_op(3, 10, 0, 3, 1'b0, 1'b1);

    // abort 1000/10 at cycle 12 with an asynchronous reset
    @(negedge clk);
    start    = 1'b1;
    dividend = 1000;
    divisor  = 10;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_quotient", 64'(quotient), 0);
    chk("abort_remainder", 64'(remainder), 0);
    chk("abort_dz", 64'(div_by_zero), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("idle_after_abort", 64'(busy), 0);

    run_op(1000, 10, 100, 0, 1'b0, 1'b0);

    for (int k = 0; k < 2000; k++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == '0) run_op(a, b, '1, a, 1'b1, 1'b0);
      else run_op(a, b, a / b, a % b, 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
